// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU datapath blocks.
//   - ALU opcode constants, also decoded by the ALU result mux.
//   - State type of the sequential popcount/parity engine.
//   - Default datapath widths.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Default operand / result bus width of the ALU.
  localparam int DEFAULT_DATA_WIDTH  = 512;
  // Default number of operand bits counted per clock by the popcount engine.
  localparam int DEFAULT_CHUNK_WIDTH = 64;

  // ALU opcodes shared with the result mux.
  localparam logic [2:0] PARITY   = 3'd0;
  localparam logic [2:0] POPCOUNT = 3'd1;
  localparam logic [2:0] ROTR     = 3'd2;
  localparam logic [2:0] ROTL     = 3'd3;

  // Popcount engine states.
  //   IDLE  : waiting for start, last result held on the outputs
  //   COUNT : one operand chunk accumulated per clock
  //   DONE  : one-cycle completion pulse, new start accepted here too
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } pc_state_e;

endpackage : alu_pkg

// File: rtl/seq_popcount_unit_if.sv
// ---------------------------------------------------------------------------
// seq_popcount_unit_if
//   Issue-side handshake and result bus of the sequential popcount engine.
//
//   Handshake: start is sampled only on a rising edge where ready is high;
//   that edge captures data_in. busy is high while counting. done is a
//   one-cycle pulse whose cycle is the first in which popcount_out and
//   parity_out show the new result; the results then hold until the next
//   completion.
//
//   Signals:
//     start        issue -> engine  request a new operation
//     data_in      issue -> engine  operand, DATA_WIDTH bits
//     ready        engine -> issue  start will be accepted on the next edge
//     busy         engine -> issue  counting in progress
//     done         engine -> issue  one-cycle completion pulse
//     popcount_out engine -> mux    number of 1s, zero-extended
//     parity_out   engine -> mux    bit0 = XOR of operand bits, rest 0
//
//   Modports: master = issue logic side, slave = popcount engine side.
// ---------------------------------------------------------------------------
interface seq_popcount_unit_if #(
  parameter int DATA_WIDTH = alu_pkg::DEFAULT_DATA_WIDTH
);

  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] popcount_out;
  logic [DATA_WIDTH-1:0] parity_out;

  modport master (
    output start,
    output data_in,
    input  ready,
    input  busy,
    input  done,
    input  popcount_out,
    input  parity_out
  );

  modport slave (
    input  start,
    input  data_in,
    output ready,
    output busy,
    output done,
    output popcount_out,
    output parity_out
  );

endinterface : seq_popcount_unit_if

// File: rtl/chunk_popcount.sv
// ---------------------------------------------------------------------------
// chunk_popcount
//   Combinational population count of one CHUNK_WIDTH-bit slice.
//
//   Ports:
//     chunk_i  CHUNK_WIDTH bits to count
//     count_o  number of 1s in chunk_i, $clog2(CHUNK_WIDTH+1) bits
// ---------------------------------------------------------------------------
module chunk_popcount #(
  parameter  int CHUNK_WIDTH = alu_pkg::DEFAULT_CHUNK_WIDTH,
  localparam int OUT_W       = $clog2(CHUNK_WIDTH + 1)
) (
  input  logic [CHUNK_WIDTH-1:0] chunk_i,
  output logic [OUT_W-1:0]       count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      count_o = count_o + OUT_W'(chunk_i[i]);
    end
  end

endmodule : chunk_popcount

// File: rtl/seq_popcount_unit.sv
// ---------------------------------------------------------------------------
// seq_popcount_unit
//   Multi-cycle population-count and parity engine. An accepted operand is
//   counted one CHUNK_WIDTH slice per clock (NUM_CHUNKS clocks), then the
//   result is published together with a one-cycle done pulse. Results hold
//   between completions so the downstream mux may register them at any edge.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     pc           slave side of seq_popcount_unit_if (start/data_in in,
//                  ready/busy/done/popcount_out/parity_out out)
//     dbg_state_o  current FSM state, for observation only
// ---------------------------------------------------------------------------
module seq_popcount_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_popcount_unit_if.slave    pc,
  output pc_state_e             dbg_state_o
);

  localparam int NUM_CHUNKS  = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_WIDTH   = $clog2(DATA_WIDTH + 1);
  localparam int CHUNK_CNT_W = $clog2(CHUNK_WIDTH + 1);
  // A single-chunk configuration still needs a 1-bit index register.
  localparam int IDX_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_width
      $error("seq_popcount_unit: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  pc_state_e             state_q,   state_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [CNT_WIDTH-1:0]  acc_q,     acc_d;
  logic [DATA_WIDTH-1:0] operand_q, operand_d;
  logic [CNT_WIDTH-1:0]  pop_q,     pop_d;
  logic                  par_q,     par_d;

  // ---------------------------------------------------------------------
  // Chunk select and count
  // ---------------------------------------------------------------------
  // Viewing the operand as an array of chunks keeps the slice mux a plain
  // indexed read; chunk 0 is the least significant slice.
  logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] chunks;
  logic [CHUNK_WIDTH-1:0]                 chunk_sel;
  logic [CHUNK_CNT_W-1:0]                 chunk_cnt;
  logic [CNT_WIDTH-1:0]                   acc_sum;

  assign chunks    = operand_q;
  assign chunk_sel = chunks[idx_q];

  chunk_popcount #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_chunk_popcount (
    .chunk_i (chunk_sel),
    .count_o (chunk_cnt)
  );

  // The total can never exceed DATA_WIDTH, which fits in CNT_WIDTH bits.
  assign acc_sum = acc_q + CNT_WIDTH'(chunk_cnt);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    pop_d     = pop_q;
    par_d     = par_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new operand exactly like IDLE, giving
        // back-to-back operation without a bubble cycle.
        if (pc.start) begin
          operand_d = pc.data_in;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = COUNT;
        end else begin
          state_d   = IDLE;
        end
      end

      COUNT: begin
        acc_d = acc_sum;
        if (idx_q == LAST_IDX) begin
          // Results are only ever written here, so they hold through
          // IDLE and through the next operation's COUNT cycles.
          pop_d   = acc_sum;
          par_d   = acc_sum[0];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      pop_q     <= '0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      pop_q     <= pop_d;
      par_q     <= par_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they are glitch-free.
  // ---------------------------------------------------------------------
  assign pc.ready        = (state_q == IDLE) || (state_q == DONE);
  assign pc.busy         = (state_q == COUNT);
  assign pc.done         = (state_q == DONE);
  assign pc.popcount_out = {{(DATA_WIDTH - CNT_WIDTH){1'b0}}, pop_q};
  assign pc.parity_out   = {{(DATA_WIDTH - 1){1'b0}}, par_q};
  assign dbg_state_o     = state_q;

endmodule : seq_popcount_unit

// File: tb/tb_seq_popcount_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_popcount_unit
//   Scoreboard bench for seq_popcount_unit. The driver pushes the reference
//   count/parity of every accepted operand; a monitor on the falling edge
//   pops and compares on each done pulse, and between pulses checks that
//   the published results hold and that busy/ready follow the operation.
// ---------------------------------------------------------------------------
module tb_seq_popcount_unit;
  import alu_pkg::*;

  localparam int DW  = 512;
  localparam int CW  = 64;
  localparam int NC  = DW / CW;
  localparam int EW  = 11;   // {parity, 10-bit count}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_popcount_unit_if #(.DATA_WIDTH(DW)) pc_bus ();
  pc_state_e dbg_state;

  seq_popcount_unit #(
    .DATA_WIDTH  (DW),
    .CHUNK_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc_bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  logic [EW-1:0] last_res = '0;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            prev_done_cyc = 0;
  int            last_done_cyc = 0;

  // Reference model: count the ones, XOR-reduce for parity.
  function automatic logic [EW-1:0] model(input logic [DW-1:0] d);
    int n;
    n = 0;
    for (int i = 0; i < DW; i++) if (d[i]) n++;
    return {^d, 10'(n)};
  endfunction

  function automatic logic [DW-1:0] pop_full(input logic [EW-1:0] r);
    logic [DW-1:0] v;
    v = '0;
    v[9:0] = r[9:0];
    return v;
  endfunction

  function automatic logic [DW-1:0] par_full(input logic [EW-1:0] r);
    logic [DW-1:0] v;
    v = '0;
    v[0] = r[10];
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic busy_exp;
      busy_exp = !pc_bus.done && (exp_q.size() > 0);
      check("busy", DW'(pc_bus.busy), DW'(busy_exp));
      check("ready", DW'(pc_bus.ready), DW'(!busy_exp));
      if (pc_bus.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1 expected done=0 (t=%0t)", $time);
        end else begin
          logic [EW-1:0] e;
          int acc_cyc;
          e       = exp_q.pop_front();
          acc_cyc = lat_q.pop_front();
          check("popcount_out", pc_bus.popcount_out, pop_full(e));
          check("parity_out", pc_bus.parity_out, par_full(e));
          check("latency", DW'(cyc - acc_cyc), DW'(NC));
          last_res = e;
        end
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
      end else begin
        check("hold_popcount", pc_bus.popcount_out, pop_full(last_res));
        check("hold_parity", pc_bus.parity_out, par_full(last_res));
      end
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic push_exp(input logic [DW-1:0] d);
    exp_q.push_back(model(d));
    lat_q.push_back(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!pc_bus.ready && guard < 200) begin
      step();
      guard++;
    end
    if (!pc_bus.ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  // Issue one operand; data_in is scrambled afterwards and must not matter.
  task automatic issue(input logic [DW-1:0] d);
    pc_bus.start   = 1'b1;
    pc_bus.data_in = d;
    wait_ready();
    step();
    push_exp(d);
    pc_bus.start   = 1'b0;
    pc_bus.data_in = {16{$urandom()}};
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !pc_bus.ready) && guard < 500) begin
      step();
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {16{$urandom()}} ^ {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    pc_bus.start   = 1'b0;
    pc_bus.data_in = '0;

    // Reset held for three cycles, then idle checks.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_ready", DW'(pc_bus.ready), DW'(1));
    check("rst_busy", DW'(pc_bus.busy), DW'(0));
    check("rst_done", DW'(pc_bus.done), DW'(0));
    check("rst_popcount", pc_bus.popcount_out, '0);
    check("rst_parity", pc_bus.parity_out, '0);
    step();

    // Single op with one bit set.
    d = '0; d[0] = 1'b1;
    issue(d);
    wait_idle();

    // Extremes: all ones, all zeros, one full chunk.
    issue('1);
    wait_idle();
    issue('0);
    wait_idle();
    d = '0; d[3*CW +: CW] = {CW{1'b1}};
    issue(d);
    wait_idle();

    // Back-to-back with start held high; a 'hFF operand offered in COUNT
    // must be ignored.
    pc_bus.start   = 1'b1;
    pc_bus.data_in = DW'(32'h7);
    wait_ready();
    step();
    push_exp(DW'(32'h7));
    pc_bus.data_in = DW'(32'hF0);
    step();
    step();
    pc_bus.data_in = DW'(32'hFF);
    step();
    pc_bus.data_in = DW'(32'hF0);
    wait_ready();
    step();
    push_exp(DW'(32'hF0));
    pc_bus.start = 1'b0;
    wait_idle();
    check("b2b_spacing", DW'(last_done_cyc - prev_done_cyc), DW'(NC + 1));
    check("b2b_last_result", pc_bus.popcount_out, DW'(4));

    // Reset during the 4th COUNT cycle aborts the operation.
    issue(rand_word());
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    last_res = '0;
    #1;
    check("midrst_popcount", pc_bus.popcount_out, '0);
    check("midrst_parity", pc_bus.parity_out, '0);
    check("midrst_busy", DW'(pc_bus.busy), DW'(0));
    check("midrst_done", DW'(pc_bus.done), DW'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    issue(DW'(32'h5));
    wait_idle();

    // Output hold: result 3, idle 20 cycles, then a new op.
    issue(DW'(32'h13));
    wait_idle();
    repeat (20) step();
    check("hold_after_idle", pc_bus.popcount_out, DW'(3));
    issue(rand_word());
    wait_idle();

    // Randomized operands and gaps, including back-to-back issue.
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: d = rand_word();
        1: d = rand_word() & rand_word() & rand_word();
        2: d = rand_word() | rand_word() | rand_word();
        default: begin
          d = '0;
          d[$urandom_range(0, NC - 1) * CW +: CW] = {$urandom(), $urandom()};
        end
      endcase
      issue(d);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule : tb_seq_popcount_unit
